// File: rtl/bcd_sevenseg_mux_if.sv
// rtl/bcd_sevenseg_mux_if.sv - BCD word, decimal points and display outputs of the 7-segment mux
interface bcd_sevenseg_mux_if;
  logic [11:0] bcd_in;
  logic [2:0]  dp_in;
  logic [3:0]  an;
  logic [7:0]  sseg;
  logic        frame_tick;

  modport master (
    output bcd_in,
    output dp_in,
    input  an,
    input  sseg,
    input  frame_tick
  );

  modport slave (
    input  bcd_in,
    input  dp_in,
    output an,
    output sseg,
    output frame_tick
  );
endinterface

// File: rtl/bcd_sevenseg_mux.sv
// rtl/bcd_sevenseg_mux.sv - 3-digit BCD to 4-digit common-anode 7-segment scan driver
// Optional leading-zero blanking of digits 2 and 1 when LEADING_ZERO_BLANK_EN is defined.
module bcd_sevenseg_mux #(
  parameter int N = 18
) (
  input  logic                 clk,
  input  logic                 reset,
  bcd_sevenseg_mux_if.slave    bus
);

  logic [N-1:0] counter;
  logic [11:0]  shadow;
  logic [2:0]   dp_shadow;
  logic [3:0]   an_q;
  logic [7:0]   sseg_q;
  logic         tick_q;

  logic [1:0]   sel;
  logic         wrap;
  logic [3:0]   an_next;
  logic [7:0]   sseg_next;
  logic [3:0]   nib;
  logic         dp;
  logic         blank;

  assign sel  = counter[N-1:N-2];
  assign wrap = &counter;

  // Segment pattern {g,f,e,d,c,b,a}, active-low; non-BCD nibbles show a dash
  function automatic logic [6:0] seg_of(input logic [3:0] v);
    case (v)
      4'd0:    seg_of = 7'h40;
      4'd1:    seg_of = 7'h79;
      4'd2:    seg_of = 7'h24;
      4'd3:    seg_of = 7'h30;
      4'd4:    seg_of = 7'h19;
      4'd5:    seg_of = 7'h12;
      4'd6:    seg_of = 7'h02;
      4'd7:    seg_of = 7'h78;
      4'd8:    seg_of = 7'h00;
      4'd9:    seg_of = 7'h10;
      default: seg_of = 7'h3F;
    endcase
  endfunction

  always_comb begin
    an_next = 4'b1111;
    nib     = 4'h0;
    dp      = 1'b0;
    blank   = 1'b0;
    case (sel)
      2'd0: begin an_next = 4'b1110; nib = shadow[3:0];  dp = dp_shadow[0]; end
      2'd1: begin an_next = 4'b1101; nib = shadow[7:4];  dp = dp_shadow[1]; end
      2'd2: begin an_next = 4'b1011; nib = shadow[11:8]; dp = dp_shadow[2]; end
      default: begin an_next = 4'b0111; blank = 1'b1; end
    endcase
`ifdef LEADING_ZERO_BLANK_EN
    if (sel == 2'd2 && shadow[11:8] == 4'h0) blank = 1'b1;
    if (sel == 2'd1 && shadow[11:4] == 8'h00) blank = 1'b1;
`endif
    sseg_next = {~dp, blank ? 7'h7F : seg_of(nib)};
  end

  // Shadow is only reloaded on the last count so a frame never mixes two words
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      counter   <= '0;
      shadow    <= 12'h000;
      dp_shadow <= 3'b000;
      an_q      <= 4'b1111;
      sseg_q    <= 8'hFF;
      tick_q    <= 1'b0;
    end else begin
      counter <= counter + 1'b1;
      if (wrap) begin
        shadow    <= bus.bcd_in;
        dp_shadow <= bus.dp_in;
      end
      tick_q <= wrap;
      an_q   <= an_next;
      sseg_q <= sseg_next;
    end
  end

  assign bus.an         = an_q;
  assign bus.sseg       = sseg_q;
  assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_bcd_sevenseg_mux.sv
// tb/tb_bcd_sevenseg_mux.sv - randomized and directed check of bcd_sevenseg_mux against a frame-level model
module tb_bcd_sevenseg_mux;
  localparam int N     = 4;
  localparam int FRAME = 1 << N;
  localparam int SLOT  = FRAME / 4;

  logic clk = 1'b0;
  logic reset;
  bcd_sevenseg_mux_if bus ();

  bcd_sevenseg_mux #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0] seg_tbl [16];
  int         m_cnt;
  logic [11:0] m_shadow;
  logic [2:0]  m_dp;
  logic [3:0]  exp_an;
  logic [7:0]  exp_sseg;
  logic        exp_tick;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Display the model expects for scan position cnt with the given frame word
  task automatic model_outputs(input int cnt, output logic [3:0] a, output logic [7:0] s);
    int d;
    logic [3:0] v;
    logic blk;
    d = cnt / SLOT;
    a = ~(4'b0001 << d);
    if (d == 3) begin
      s = 8'hFF;
    end else begin
      v = m_shadow[4*d +: 4];
      blk = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      if (d == 2 && m_shadow[11:8] == 4'h0) blk = 1'b1;
      if (d == 1 && m_shadow[11:4] == 8'h00) blk = 1'b1;
`endif
      s = blk ? 8'hFF : seg_tbl[v];
      if (m_dp[d]) s = s & 8'h7F;
    end
  endtask

  task automatic step();
    model_outputs(m_cnt, exp_an, exp_sseg);
    exp_tick = (m_cnt == FRAME - 1);
    if (m_cnt == FRAME - 1) begin
      m_shadow = bus.bcd_in;
      m_dp     = bus.dp_in;
    end
    m_cnt = (m_cnt + 1) % FRAME;
    @(posedge clk);
    @(negedge clk);
    chk("an", {4'h0, bus.an}, {4'h0, exp_an});
    chk("sseg", bus.sseg, exp_sseg);
    chk("frame_tick", {7'h0, bus.frame_tick}, {7'h0, exp_tick});
  endtask

  // Run until the new word has been captured (start of the next frame)
  task automatic load(input logic [11:0] b, input logic [2:0] p);
    bit ok = 0;
    bus.bcd_in = b;
    bus.dp_in  = p;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      if (m_cnt == 0 && m_shadow == b && m_dp == p) begin ok = 1; break; end
    end
    chk("load_timeout", {7'h0, ok}, 8'h01);
  endtask

  task automatic show(input int d, input logic [7:0] expv, input string tag);
    bit ok = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      if (exp_an == ~(4'b0001 << d)) begin ok = 1; break; end
    end
    chk({tag, "_reach"}, {7'h0, ok}, 8'h01);
    chk(tag, bus.sseg, expv);
  endtask

  task automatic model_reset();
    m_cnt    = 0;
    m_shadow = 12'h000;
    m_dp     = 3'b000;
  endtask

  initial begin
    seg_tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                8'h80, 8'h90, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF};
    model_reset();
    reset      = 1'b1;
    bus.bcd_in = 12'h000;
    bus.dp_in  = 3'b000;
    #1;
    chk("rst_an", {4'h0, bus.an}, 8'h0F);
    chk("rst_sseg", bus.sseg, 8'hFF);
    chk("rst_tick", {7'h0, bus.frame_tick}, 8'h00);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Two frames of 000: scan order, blank digit 3, frame_tick period
    for (int i = 0; i < 2 * FRAME; i++) step();

    // New word mid-frame must not tear the current frame
    while (m_cnt != 5) step();
    bus.bcd_in = 12'h259;
    load(12'h259, 3'b000);
    show(0, 8'h90, "d0_259");
    show(1, 8'h92, "d1_259");
    show(2, 8'hA4, "d2_259");

    load(12'h3A7, 3'b000);
    show(0, 8'hF8, "d0_3A7");
    show(1, 8'hBF, "d1_dash");
    show(2, 8'hB0, "d2_3A7");

    load(12'h105, 3'b010);
    show(0, 8'h92, "d0_105");
    show(1, 8'h40, "d1_dp");
    show(2, 8'hF9, "d2_105");

    load(12'h007, 3'b000);
`ifdef LEADING_ZERO_BLANK_EN
    show(0, 8'hF8, "lz_d0_007");
    show(1, 8'hFF, "lz_d1_007");
    show(2, 8'hFF, "lz_d2_007");
    load(12'h070, 3'b000);
    show(0, 8'hC0, "lz_d0_070");
    show(1, 8'hF8, "lz_d1_070");
    show(2, 8'hFF, "lz_d2_070");
`else
    show(0, 8'hF8, "d0_007");
    show(1, 8'hC0, "d1_007");
    show(2, 8'hC0, "d2_007");
`endif

    // Random words, dp requests and change times, checked every cycle
    for (int i = 0; i < 30 * FRAME; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        bus.bcd_in = 12'($urandom);
        bus.dp_in  = 3'($urandom);
      end
      step();
    end

    // Asynchronous reset while digit 2 is on screen
    bus.bcd_in = 12'h468;
    bus.dp_in  = 3'b111;
    show(2, exp_sseg, "pre_rst");
    #2;
    reset = 1'b1;
    #1;
    chk("async_an", {4'h0, bus.an}, 8'h0F);
    chk("async_sseg", bus.sseg, 8'hFF);
    chk("async_tick", {7'h0, bus.frame_tick}, 8'h00);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    step();
    chk("post_rst_an", {4'h0, bus.an}, 8'h0E);
    chk("post_rst_sseg", bus.sseg, 8'hC0);
    for (int i = 0; i < 3 * FRAME; i++) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_sevenseg_mux.md
Name: bcd_sevenseg_mux

Overview:
- Downstream display stage for the 3-digit BCD counter. Consumes the packed 12-bit BCD word {B2,B1,B0} and time-multiplexes it onto a 4-digit common-anode 7-segment display.
- Contains a free-running refresh counter, a frame-coherent shadow register (no tearing mid-scan), a BCD-to-segment decoder and registered anode/segment outputs.
- Digit 3 (leftmost) is always blank.

Parameters:
- N, 18, refresh counter width. The top 2 bits select the digit. At 100 MHz, N=18 gives roughly 381 Hz per digit.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- bcd_in  input  12  packed BCD {B2[11:8], B1[7:4], B0[3:0]}
- dp_in  input  3  decimal point request per digit, dp_in[k] for digit k, active-high
- an  output  4  anode enables, active-low, an[k] = digit k
- sseg  output  8  segments {dp,g,f,e,d,c,b,a}, active-low
- frame_tick  output  1  one-cycle pulse on the final cycle of each scan frame

Behaviour:
- Reset (asynchronous, active-high) forces:
  - counter = 0, shadow = 12'h000, dp_shadow = 3'b000
  - an = 4'b1111, sseg = 8'hFF, frame_tick = 0
- Counter:
  - N-bit up-counter, +1 every clk.
  - Wraps from 2^N-1 to 0 with no stall.
  - sel = counter[N-1:N-2].
- Shadow capture:
  - When counter == 2^N-1, shadow <= bcd_in and dp_shadow <= dp_in.
  - The new values are displayed starting at counter == 0.
  - Changes to bcd_in at any other time have no effect until the next frame.
- frame_tick:
  - Registered; high for exactly the one cycle after counter == 2^N-1, i.e. coincident with counter == 0.
  - Period is 2^N cycles.
- Digit select (outputs registered, one clk after sel changes):
  - sel 0: an=4'b1110, digit = shadow[3:0], dp = dp_shadow[0]
  - sel 1: an=4'b1101, digit = shadow[7:4], dp = dp_shadow[1]
  - sel 2: an=4'b1011, digit = shadow[11:8], dp = dp_shadow[2]
  - sel 3: an=4'b0111, sseg = 8'hFF (blank, dp off)
- Decode, sseg[6:0] with dp off (bit7=1):
  - 0:C0, 1:F9, 2:A4, 3:B0, 4:99, 5:92, 6:82, 7:F8, 8:80, 9:90
- Decode rules:
  - Non-BCD nibble (A-F) displays a dash, 8'hBF.
  - dp request clears bit7 (e.g. "5." = 8'h12). This applies to digits, dashes and blanks alike.
- Exactly one anode is low at any time after the first post-reset clock.
- Reset asserted mid-frame: outputs go to their reset values immediately. The scan restarts at digit 0 with shadow = 0 once reset is released. The first displayed frame after reset shows 000.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN
- Defined:
  - Digit 2 blanks when shadow[11:8]==0.
  - Digit 1 blanks when shadow[11:8]==0 and shadow[7:4]==0.
  - A blanked digit outputs sseg = {~dp,7'h7F}, so its dp is still honoured.
  - Digit 0 is never blanked.
  - Anodes still scan normally.
- Undefined: all three digits always display, leading zeros included.

Test Plan (N=4 in simulation, frame = 16 cycles):
- Reset, then release with bcd_in=12'h000 -> an cycles 1110,1101,1011,0111 every 4 clks; sseg C0,C0,C0,FF; frame_tick pulses every 16 clks.
- bcd_in=12'h259 applied at counter==5 -> current frame still shows 000; next frame shows digit0=90, digit1=92, digit2=A4.
- bcd_in=12'h3A7 -> digit1 shows BF (dash), digit0=F8, digit2=B0.
- dp_in=3'b010, bcd_in=12'h105 -> digit1 sseg=8'h40, digit0=92, digit2=F9.
- LEADING_ZERO_BLANK_EN defined, bcd_in=12'h007 -> digit2=FF, digit1=FF, digit0=F8. With bcd_in=12'h070 -> digit2=FF, digit1=F8, digit0=C0.
- Assert reset while sel==2 -> an=1111, sseg=FF in the same cycle, with no clock edge needed. On release, the scan resumes at digit 0 showing C0.
